// File: rtl/gb_frame_writer.sv
// PPU pixel capture and frame-buffer write controller with optional ping-pong banking.
// Double buffering is enabled by defining GB_FB_DOUBLE_BUFFER_EN; otherwise a single bank is used.
module gb_frame_writer #(
  parameter int H_PIXELS = 160,
  parameter int V_PIXELS = 144,
  parameter int PIX_W    = 2,
  parameter int ADDR_W   = 15,
  parameter int X_W      = 8,
  parameter int Y_W      = 8
) (
  input  logic              GameBoy_clk,
  input  logic              GameBoy_reset,
  input  logic [PIX_W-1:0]  px_data,
  input  logic              px_valid,
  input  logic              px_vsync,
  input  logic              disp_frame_start,
  output logic              fb_we,
  output logic [ADDR_W-1:0] fb_waddr,
  output logic [PIX_W-1:0]  fb_wdata,
  output logic              fb_wbank,
  output logic              fb_rbank,
  output logic              frame_done,
  output logic [X_W-1:0]    cur_x,
  output logic [Y_W-1:0]    cur_y,
  output logic [7:0]        overrun_cnt
);

`ifdef GB_FB_DOUBLE_BUFFER_EN
  localparam bit DOUBLE_BUF = 1'b1;
`else
  localparam bit DOUBLE_BUF = 1'b0;
`endif

  localparam logic [X_W-1:0] X_LAST = X_W'(H_PIXELS - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_PIXELS - 1);

  typedef enum logic {FILL, HOLD} state_t;

  state_t              state_reg, state_next;
  logic [X_W-1:0]      x_reg, x_next;
  logic [Y_W-1:0]      y_reg, y_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic                we_reg, we_next;
  logic [ADDR_W-1:0]   waddr_reg, waddr_next;
  logic [PIX_W-1:0]    wdata_reg, wdata_next;
  logic                done_reg, done_next;
  logic                wbank_reg, wbank_next;
  logic [7:0]          ovr_reg, ovr_next;

  // vsync restarts the raster; a pixel in the same cycle lands at address 0
  logic [X_W-1:0]      base_x;
  logic [Y_W-1:0]      base_y;
  logic [ADDR_W-1:0]   base_addr;

  assign base_x    = px_vsync ? '0 : x_reg;
  assign base_y    = px_vsync ? '0 : y_reg;
  assign base_addr = px_vsync ? '0 : addr_reg;

  always_ff @(posedge GameBoy_clk or posedge GameBoy_reset) begin
    if (GameBoy_reset) begin
      state_reg <= FILL;
      x_reg     <= '0;
      y_reg     <= '0;
      addr_reg  <= '0;
      we_reg    <= 1'b0;
      waddr_reg <= '0;
      wdata_reg <= '0;
      done_reg  <= 1'b0;
      wbank_reg <= 1'b0;
      ovr_reg   <= 8'd0;
    end else begin
      state_reg <= state_next;
      x_reg     <= x_next;
      y_reg     <= y_next;
      addr_reg  <= addr_next;
      we_reg    <= we_next;
      waddr_reg <= waddr_next;
      wdata_reg <= wdata_next;
      done_reg  <= done_next;
      wbank_reg <= wbank_next;
      ovr_reg   <= ovr_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    wbank_next = wbank_reg;
    ovr_next   = ovr_reg;
    we_next    = 1'b0;
    done_next  = 1'b0;
    waddr_next = waddr_reg;
    wdata_next = wdata_reg;
    x_next     = base_x;
    y_next     = base_y;
    addr_next  = base_addr;

    // Swap has priority over an overrun so a coincident pixel goes to the new bank
    if (state_reg == HOLD) begin
      if (disp_frame_start) begin
        wbank_next = ~wbank_reg;
        state_next = FILL;
      end else if (px_valid) begin
        if (ovr_reg != 8'hFF)
          ovr_next = ovr_reg + 8'd1;
        state_next = FILL;
      end
    end

    if (px_valid) begin
      we_next    = 1'b1;
      waddr_next = base_addr;
      wdata_next = px_data;
      if (base_x == X_LAST) begin
        x_next = '0;
        if (base_y == Y_LAST) begin
          y_next     = '0;
          addr_next  = '0;
          done_next  = 1'b1;
          state_next = DOUBLE_BUF ? HOLD : FILL;
        end else begin
          y_next    = base_y + Y_W'(1);
          addr_next = base_addr + ADDR_W'(1);
        end
      end else begin
        x_next    = base_x + X_W'(1);
        addr_next = base_addr + ADDR_W'(1);
      end
    end
  end

  assign fb_we       = we_reg;
  assign fb_waddr    = waddr_reg;
  assign fb_wdata    = wdata_reg;
  assign frame_done  = done_reg;
  assign fb_wbank    = wbank_reg;
  assign fb_rbank    = DOUBLE_BUF ? ~wbank_reg : 1'b0;
  assign cur_x       = x_reg;
  assign cur_y       = y_reg;
  assign overrun_cnt = ovr_reg;

endmodule

// File: doc/gb_frame_writer.md
# gb_frame_writer

Parametrised pixel-capture and frame-buffer write controller in the GameBoy clock domain. Takes the PPU's pixel stream, generates linear frame-buffer write addresses without a multiplier, and manages a ping-pong (double) buffer: the writer fills one bank while the VGA side reads the other. Banks swap only at a display frame boundary, so the display never tears. It sits between the PPU pixel conduit and the dual-clock frame-buffer RAM that feeds the VGA scaler.

## Interface
Parameters:
- H_PIXELS, 160, active pixels per line
- V_PIXELS, 144, active lines per frame
- PIX_W, 2, bits per pixel
- ADDR_W, 15, frame-buffer address width per bank; must satisfy 2^ADDR_W ≥ H_PIXELS·V_PIXELS
- X_W, 8, width of x counter
- Y_W, 8, width of y counter

Ports:
- GameBoy_clk  in  1  2^22 Hz GameBoy clock; all logic on rising edge
- GameBoy_reset  in  1  asynchronous, active-high reset
- px_data  in  PIX_W  pixel value, qualified by px_valid
- px_valid  in  1  one pixel per asserted cycle, raster order
- px_vsync  in  1  single-cycle pulse at PPU frame start; resynchronises counters
- disp_frame_start  in  1  single-cycle pulse from the display side, already synchronised into GameBoy_clk
- fb_we  out  1  frame-buffer write enable
- fb_waddr  out  ADDR_W  write address, y·H_PIXELS + x
- fb_wdata  out  PIX_W  registered px_data
- fb_wbank  out  1  bank being written
- fb_rbank  out  1  bank the display must read; always ~fb_wbank when double buffering is enabled
- frame_done  out  1  one-cycle pulse with the write of the last pixel
- cur_x  out  X_W  x of the next expected pixel
- cur_y  out  Y_W  y of the next expected pixel
- overrun_cnt  out  8  saturating count of completed frames discarded before the swap

## Operation
- Counters: x increments on px_valid. At x = H_PIXELS−1, x wraps to 0 and y increments. Linear address increments by 1 per pixel, with no multiply.
- Last pixel: x = H_PIXELS−1 and y = V_PIXELS−1. Accepting it pulses frame_done, resets counters to 0, and enters HOLD.
- px_vsync: counters and address reset to 0. A partial frame is discarded without setting pending or incrementing overrun_cnt. If px_vsync and px_valid occur in the same cycle, the pixel is written to address 0 and the next address is 1.
- FSM states:
  - FILL: writing fb_wbank. Last pixel → HOLD.
  - HOLD: completed frame waits for the swap.
    - disp_frame_start → toggle fb_wbank/fb_rbank, then FILL.
    - px_valid before the swap → overrun_cnt++ (saturates at 255); pixel written to address 0 of the same bank; FILL; the completed frame is lost.
    - Both in the same cycle → swap first, and the pixel goes to the new write bank at address 0; no overrun.
- disp_frame_start in FILL: ignored.
- fb_rbank changes only on a swap.

## Timing
- Pixel to write latency is 1 cycle: px_valid at edge n → fb_we, fb_waddr, fb_wdata valid after edge n+1, for one cycle.
- frame_done is coincident with fb_we for the last pixel.
- The swap is visible on fb_wbank/fb_rbank one cycle after the disp_frame_start edge.
- If disp_frame_start arrives in the same cycle as the last px_valid, there is no swap: HOLD is not yet entered. The next disp_frame_start performs the swap.
- Reset values (asynchronous, immediate):
  - fb_we = 0, fb_waddr = 0, fb_wdata = 0, frame_done = 0
  - fb_wbank = 0, fb_rbank = 1
  - cur_x = 0, cur_y = 0, overrun_cnt = 0
  - state = FILL
- Reset mid-frame discards all progress. After release, the first px_valid writes address 0, bank 0.

## Configuration
- GB_FB_DOUBLE_BUFFER_EN defined: ping-pong behaviour as above.
- GB_FB_DOUBLE_BUFFER_EN undefined:
  - Single bank; no HOLD state.
  - fb_wbank = fb_rbank = 0 constant.
  - The last pixel wraps directly back to FILL at address 0.
  - frame_done still pulses.
  - disp_frame_start is ignored; overrun_cnt stays 0.

## Test plan
- Reset, then 23040 px_valid with px_data = i mod 4 → fb_waddr runs 0..23039 on bank 0 with matching data; frame_done pulses exactly once, with address 23039; cur_x = cur_y = 0.
- After a full frame, pulse disp_frame_start → fb_wbank = 1 and fb_rbank = 0 one cycle later. The next pixel writes address 0, bank 1.
- A full frame, then 5 pixels with no disp_frame_start → overrun_cnt = 1; the 5 pixels go to addresses 0..4 of bank 0; no swap.
- After 1000 pixels, px_vsync together with px_valid → that pixel is written at address 0; the next is at address 1; no frame_done; overrun_cnt unchanged.
- In HOLD, disp_frame_start and px_valid in the same cycle → swap to bank 1, pixel at bank 1 address 0, overrun_cnt = 0.
- Assert GameBoy_reset at pixel 12000 of the second frame (bank 1) → all outputs return to reset values immediately (fb_wbank = 0, fb_rbank = 1); the first post-reset pixel writes address 0, bank 0.
